// File: rtl/execute_muldiv_unit.sv
// execute_muldiv_unit: single-cycle ALU plus iterative shift-add multiplier and restoring divider.
// Divider (ops 6-7) exists only when EXECUTE_MULDIV_DIV_EN is defined; otherwise ops 6-7 return 0 in one cycle.
module execute_muldiv_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int OP_WIDTH       = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_in,
    input  logic                      in_valid_in,
    output logic                      in_ready_out,
    input  logic [OP_WIDTH-1:0]       op_in,
    input  logic [DATA_WIDTH-1:0]     data_a_in,
    input  logic [DATA_WIDTH-1:0]     data_b_in,
    input  logic [REG_ADDR_WIDTH-1:0] reg_addr_in,
    output logic                      out_valid_out,
    input  logic                      out_ready_in,
    output logic [DATA_WIDTH-1:0]     result_out,
    output logic [REG_ADDR_WIDTH-1:0] reg_addr_out,
    output logic                      busy_out
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

`ifdef EXECUTE_MULDIV_DIV_EN
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd3} state_t;
`endif

    state_t                    state_q, state_d;
    logic [W-1:0]              hi_q, hi_d, lo_q, lo_d, opd_q, opd_d, res_q, res_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      sel_q, sel_d, valid_q, valid_d;
    logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                      accept, is_mul, is_div;
    logic [W-1:0]              alu;
    logic [W:0]                mul_sum;
`ifdef EXECUTE_MULDIV_DIV_EN
    logic [W:0]                div_sh;
    logic                      div_ge;
`endif

    assign in_ready_out  = (state_q == IDLE) && (!valid_q || out_ready_in);
    assign busy_out      = state_q != IDLE;
    assign out_valid_out = valid_q;
    assign result_out    = res_q;
    assign reg_addr_out  = addr_q;
    assign accept        = in_valid_in && in_ready_out && !flush_in;
    assign is_mul        = (op_in == OP_WIDTH'(4)) || (op_in == OP_WIDTH'(5));
`ifdef EXECUTE_MULDIV_DIV_EN
    assign is_div        = (op_in == OP_WIDTH'(6)) || (op_in == OP_WIDTH'(7));
    // Shifted partial remainder; a zero divisor always "fits", giving all-ones quotient and remainder = dividend.
    assign div_sh        = {hi_q, lo_q[W-1]};
    assign div_ge        = div_sh >= {1'b0, opd_q};
`else
    assign is_div        = 1'b0;
`endif

    always_comb begin
        alu = (op_in == OP_WIDTH'(0)) ? data_a_in + data_b_in :
              (op_in == OP_WIDTH'(1)) ? data_a_in - data_b_in :
              (op_in == OP_WIDTH'(2)) ? data_a_in & data_b_in :
              (op_in == OP_WIDTH'(3)) ? data_a_in | data_b_in : '0;
        mul_sum = {1'b0, hi_q} + {1'b0, lo_q[0] ? opd_q : '0};
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opd_d   = opd_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        addr_d  = addr_q;
        valid_d = valid_q && !out_ready_in;
        if (flush_in) begin
            state_d = IDLE;
            valid_d = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    addr_d = reg_addr_in;
                    sel_d  = op_in[0];
                    cnt_d  = '0;
                    hi_d   = '0;
                    if (is_mul) begin
                        state_d = MUL;
                        lo_d    = data_b_in;
                        opd_d   = data_a_in;
                    end else if (is_div) begin
`ifdef EXECUTE_MULDIV_DIV_EN
                        state_d = DIV;
`endif
                        lo_d    = data_a_in;
                        opd_d   = data_b_in;
                    end else begin
                        res_d   = alu;
                        valid_d = 1'b1;
                    end
                end
                MUL: begin
                    hi_d    = mul_sum[W:1];
                    lo_d    = {mul_sum[0], lo_q[W-1:1]};
                    cnt_d   = cnt_q + CW'(1);
                    state_d = (cnt_q == CW'(W - 1)) ? DONE : MUL;
                end
`ifdef EXECUTE_MULDIV_DIV_EN
                DIV: begin
                    hi_d    = div_ge ? W'(div_sh - {1'b0, opd_q}) : div_sh[W-1:0];
                    lo_d    = {lo_q[W-2:0], div_ge};
                    cnt_d   = cnt_q + CW'(1);
                    state_d = (cnt_q == CW'(W - 1)) ? DONE : DIV;
                end
`endif
                // hi holds product high half / remainder, lo holds product low half / quotient.
                DONE: begin
                    res_d   = sel_q ? hi_q : lo_q;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            opd_q   <= '0;
            sel_q   <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opd_q   <= opd_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: tb/tb_execute_muldiv_unit.sv
// tb_execute_muldiv_unit: directed vectors with hand-computed results for execute_muldiv_unit.
// Divider expectations follow EXECUTE_MULDIV_DIV_EN.
module tb_execute_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0, rst_n = 1'b0, flush_in = 1'b0, in_valid_in = 1'b0, out_ready_in = 1'b1;
    logic [2:0]   op_in = '0;
    logic [W-1:0] data_a_in = '0, data_b_in = '0;
    logic [4:0]   reg_addr_in = '0;
    logic         in_ready_out, out_valid_out, busy_out;
    logic [W-1:0] result_out;
    logic [4:0]   reg_addr_out;
    int           n_cmp = 0, n_bad = 0;

    execute_muldiv_unit dut (
        .clk(clk), .rst_n(rst_n), .flush_in(flush_in), .in_valid_in(in_valid_in),
        .in_ready_out(in_ready_out), .op_in(op_in), .data_a_in(data_a_in), .data_b_in(data_b_in),
        .reg_addr_in(reg_addr_in), .out_valid_out(out_valid_out), .out_ready_in(out_ready_in),
        .result_out(result_out), .reg_addr_out(reg_addr_out), .busy_out(busy_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] ra);
        op_in = op; data_a_in = a; data_b_in = b; reg_addr_in = ra; in_valid_in = 1'b1;
        step();
        in_valid_in = 1'b0;
    endtask

    task automatic single(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [4:0] ra, input logic [W-1:0] exp);
        issue(op, a, b, ra);
        check({tag, "_valid"}, out_valid_out, 1);
        check({tag, "_res"}, result_out, exp);
        check({tag, "_addr"}, reg_addr_out, ra);
    endtask

    // Counts edges after the accept edge until valid; busy must stay high and ready low meanwhile.
    task automatic multi(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] ra, input logic [W-1:0] exp);
        int n, viol;
        issue(op, a, b, ra);
        n = 0; viol = 0;
        while (!out_valid_out && n < 100) begin
            if (!busy_out || in_ready_out) viol++;
            step();
            n++;
        end
        check({tag, "_lat"}, n, W + 1);
        check({tag, "_busy"}, viol, 0);
        check({tag, "_res"}, result_out, exp);
        check({tag, "_addr"}, reg_addr_out, ra);
        step();
        check({tag, "_clr"}, out_valid_out, 0);
    endtask

    task automatic quiet(input string tag);
        int cnt;
        cnt = 0;
        repeat (40) begin
            if (out_valid_out) cnt++;
            step();
        end
        check(tag, cnt, 0);
    endtask

    initial begin
        #2;
        check("rst_valid", out_valid_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_res", result_out, 0);
        check("rst_addr", reg_addr_out, 0);
        repeat (2) step();
        rst_n = 1'b1;
        #1;
        check("rst_rdy", in_ready_out, 1);

        single("add_wrap", 3'd0, 32'hFFFF_FFFF, 32'h1, 5'd3, 32'h0);
        single("sub", 3'd1, 32'd3, 32'd5, 5'd4, 32'hFFFF_FFFE);
        single("and", 3'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd5, 32'h00F0_1200);
        single("or", 3'd3, 32'hF000_0001, 32'h0000_8000, 5'd6, 32'hF000_8001);
        step();
        check("b2b_clr", out_valid_out, 0);

        out_ready_in = 1'b0;
        single("bp_add", 3'd0, 32'd10, 32'd20, 5'd7, 32'd30);
        op_in = 3'd0; data_a_in = 32'd1; data_b_in = 32'd1; reg_addr_in = 5'd9; in_valid_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_res", result_out, 32'd30);
            check("bp_addr", reg_addr_out, 5'd7);
            check("bp_valid", out_valid_out, 1);
            check("bp_rdy", in_ready_out, 0);
            step();
        end
        out_ready_in = 1'b1;
        #1;
        check("bp_rel_rdy", in_ready_out, 1);
        step();
        in_valid_in = 1'b0;
        check("bp_next_res", result_out, 32'd2);
        check("bp_next_addr", reg_addr_out, 5'd9);
        check("bp_next_valid", out_valid_out, 1);
        step();
        check("bp_clr", out_valid_out, 0);

        multi("mulhi_max", 3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'hFFFF_FFFE);
        multi("mullo_max", 3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 32'h1);
        multi("mulhi_pow", 3'd5, 32'h0001_0000, 32'h0001_0000, 5'd15, 32'h1);
        multi("mullo_small", 3'd4, 32'd1234, 32'd5678, 5'd16, 32'h006A_E9BC);

        issue(3'd4, 32'd1234, 32'd5678, 5'd10);
        repeat (9) step();
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        check("flush_busy", busy_out, 0);
        check("flush_valid", out_valid_out, 0);
        check("flush_rdy", in_ready_out, 1);
        quiet("flush_no_out");
        single("add_after_flush", 3'd0, 32'd1, 32'd1, 5'd11, 32'd2);

`ifdef EXECUTE_MULDIV_DIV_EN
        multi("divu", 3'd6, 32'd100, 32'd7, 5'd17, 32'd14);
        multi("remu", 3'd7, 32'd100, 32'd7, 5'd18, 32'd2);
        multi("divu_zero", 3'd6, 32'd5, 32'd0, 5'd19, 32'hFFFF_FFFF);
        multi("remu_zero", 3'd7, 32'd5, 32'd0, 5'd20, 32'd5);
        issue(3'd6, 32'd100, 32'd7, 5'd12);
`else
        single("divu_off", 3'd6, 32'd100, 32'd7, 5'd17, 32'd0);
        single("remu_off", 3'd7, 32'd100, 32'd7, 5'd18, 32'd0);
        step();
        issue(3'd4, 32'd100, 32'd7, 5'd12);
`endif
        repeat (5) step();
        check("mid_busy", busy_out, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy_out, 0);
        check("arst_valid", out_valid_out, 0);
        check("arst_res", result_out, 0);
        check("arst_addr", reg_addr_out, 0);
        repeat (2) step();
        rst_n = 1'b1;
        #1;
        check("arst_rdy", in_ready_out, 1);
        quiet("arst_no_out");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/execute_muldiv_unit.md
EXECUTE_MULDIV_UNIT -- requirements
Module: execute_muldiv_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width (even, >=8).
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 5, destination register address width.
REQ-003 SHALL have parameter OP_WIDTH, default 3, operation code width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port flush_in  input  1  abort in-flight operation, discard pending result.
REQ-007 SHALL have port in_valid_in  input  1  operands/op valid from decode.
REQ-008 SHALL have port in_ready_out  output  1  unit accepts new operation this cycle.
REQ-009 SHALL have port op_in  input  OP_WIDTH  operation code.
REQ-010 SHALL have port data_a_in / data_b_in  input  DATA_WIDTH each  forwarded operands.
REQ-011 SHALL have port reg_addr_in  input  REG_ADDR_WIDTH  destination register.
REQ-012 SHALL have port out_valid_out  output  1  result valid to memory stage.
REQ-013 SHALL have port out_ready_in  input  1  memory stage accepts result.
REQ-014 SHALL have port result_out  output  DATA_WIDTH  registered result.
REQ-015 SHALL have port reg_addr_out  output  REG_ADDR_WIDTH  destination captured at accept.
REQ-016 SHALL have port busy_out  output  1  iterative operation in progress (hazard stall to decode).

Function
REQ-017 SHALL decode op_in: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 MULLO (low half, unsigned), 5 MULHI (high half, unsigned), 6 DIVU (quotient), 7 REMU (remainder); arithmetic modulo 2^DATA_WIDTH.
REQ-018 SHALL accept an operation when in_valid_in && in_ready_out at a rising edge; operands, op and reg_addr captured then.
REQ-019 SHALL use FSM IDLE, MUL, DIV, DONE; reset state IDLE.
REQ-020 SHALL in IDLE assert in_ready_out when out_valid_out is 0 or out_ready_in is 1.
REQ-021 SHALL complete ops 0-3 in IDLE: result_out and out_valid_out registered on the accept edge (latency 1 cycle).
REQ-022 SHALL move ops 4-5 to MUL: radix-2 shift-add, one bit per cycle, exactly DATA_WIDTH cycles, then DONE.
REQ-023 SHALL move ops 6-7 to DIV: restoring division, one quotient bit per cycle, exactly DATA_WIDTH cycles, then DONE.
REQ-024 SHALL deassert in_ready_out and assert busy_out in MUL, DIV and DONE.
REQ-025 SHALL in DONE register result, set out_valid_out, return to IDLE next edge (total latency DATA_WIDTH+2 cycles accept-to-valid).
REQ-026 SHALL hold result_out, reg_addr_out, out_valid_out stable while out_valid_out && !out_ready_in.
REQ-027 SHALL clear out_valid_out on out_ready_in unless a new single-cycle result is loaded the same edge (back-to-back throughput 1/cycle for ops 0-3).
REQ-028 SHALL for divide by zero return quotient all ones and remainder equal to data_a.
REQ-029 SHALL on flush_in (highest priority) return FSM to IDLE, clear out_valid_out and busy_out next edge; in-flight op discarded; in_valid_in ignored that cycle.

Reset
REQ-030 SHALL asynchronously on rst_n low set FSM IDLE, out_valid_out 0, busy_out 0, result_out 0, reg_addr_out 0, internal accumulators/counter 0.
REQ-031 SHALL abort any MUL/DIV op when reset asserts mid-operation; no result emitted after release.
REQ-032 SHALL present in_ready_out 1 on the first cycle after rst_n deasserts.

Configuration
REQ-033 SHALL support macro EXECUTE_MULDIV_DIV_EN: defined -> DIV state and ops 6-7 as specified.
REQ-034 SHALL when EXECUTE_MULDIV_DIV_EN undefined omit DIV state/divider logic; ops 6-7 complete in 1 cycle with result_out 0.

Verification
REQ-035 SHALL cover ADD 0xFFFFFFFF+1 accepted cycle N -> out_valid_out cycle N+1, result 0x00000000; SUB 3-5 -> 0xFFFFFFFE.
REQ-036 SHALL cover MULHI 0xFFFFFFFF*0xFFFFFFFF -> result 0xFFFFFFFE after 34 cycles, busy_out high throughout, in_ready_out low.
REQ-037 SHALL cover DIVU 100/7 -> 14, REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5.
REQ-038 SHALL cover out_ready_in held 0 for 5 cycles after ADD result -> result/reg_addr stable, in_ready_out low, released on out_ready_in 1.
REQ-039 SHALL cover flush_in at cycle 10 of MULLO -> FSM IDLE, no out_valid_out; following ADD 1+1 -> 2 with latency 1.
REQ-040 SHALL cover rst_n low mid-DIVU -> all outputs 0 asynchronously, no result after release; repeat build without EXECUTE_MULDIV_DIV_EN -> DIVU returns 0 in 1 cycle.
